// File: rtl/timer_cnt_ctrl.sv
// rtl/timer_cnt_ctrl.sv - 64-bit prescaled timer counter with debug halt and compare interrupt
module timer_cnt_ctrl #(
  parameter int MAX_DIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_en,
  input  logic        div_en,
  input  logic [3:0]  div_val,
  input  logic        halt_req,
  input  logic        debug_mode,
  input  logic        tdr0_wr_en,
  input  logic        tdr1_wr_en,
  input  logic [31:0] wr_count,
  input  logic [63:0] cmp_val,
  output logic [31:0] lsb_count,
  output logic [31:0] msb_count,
  output logic        cnt_tick,
  output logic        halt_ack,
  output logic        int_set
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_div_cnt;
  logic [7:0]  w_div_cnt_nxt;
  logic [3:0]  r_div_val_q;
  logic [31:0] r_lsb;
  logic [31:0] r_msb;
  logic [31:0] w_lsb_nxt;
  logic [31:0] w_msb_nxt;
  logic        r_cnt_tick;
  logic        r_tick_only;
  logic        r_halt_ack;
  logic        r_int_set;

  logic [3:0]  w_div_exp;
  logic [8:0]  w_div_term;
  logic        w_dv_chg;
  logic        w_tick;
  logic        w_carry;

  // Exponent clamp; the terminal count is computed 9 bits wide so 2^8-1 is representable.
  assign w_div_exp  = (int'(div_val) > MAX_DIV) ? 4'(MAX_DIV) : div_val;
  assign w_div_term = (9'd1 << w_div_exp) - 9'd1;
  assign w_dv_chg   = (div_val != r_div_val_q);
  assign w_carry    = &r_lsb;

  // A changed exponent restarts the prescaler, so that cycle never ticks when prescaling.
  assign w_tick = (r_state == S_COUNT) &&
                  (!div_en || (!w_dv_chg && ({1'b0, r_div_cnt} == w_div_term)));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; dropping timer_en always returns to IDLE first.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (timer_en) w_state_nxt = S_COUNT;
      S_COUNT: begin
        if (!timer_en)                   w_state_nxt = S_IDLE;
        else if (halt_req && debug_mode) w_state_nxt = S_HALT;
      end
      S_HALT: begin
        if (!timer_en)                     w_state_nxt = S_IDLE;
        else if (!halt_req || !debug_mode) w_state_nxt = S_COUNT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Prescaler next value: cleared when idle/bypassed/retuned, frozen in HALT.
  always_comb begin
    w_div_cnt_nxt = r_div_cnt;
    if ((r_state == S_IDLE) || !div_en || w_dv_chg) w_div_cnt_nxt = 8'd0;
    else if (r_state == S_COUNT)                    w_div_cnt_nxt = w_tick ? 8'd0 : r_div_cnt + 8'd1;
  end

  // Prescaler and exponent-history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt   <= 8'd0;
      r_div_val_q <= 4'd0;
    end else begin
      r_div_cnt   <= w_div_cnt_nxt;
      r_div_val_q <= div_val;
    end
  end

  // Counter next value: a written half takes wr_count and blocks carry into the upper half.
  always_comb begin
    w_lsb_nxt = r_lsb;
    w_msb_nxt = r_msb;
    if (w_tick) begin
      w_lsb_nxt = r_lsb + 32'd1;
      w_msb_nxt = r_msb + {31'd0, w_carry};
    end
    if (tdr0_wr_en) begin
      w_lsb_nxt = wr_count;
      w_msb_nxt = r_msb;
    end
    if (tdr1_wr_en) w_msb_nxt = wr_count;
  end

  // Counter, tick and status registers; int_set compares the value a pure tick produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lsb       <= 32'd0;
      r_msb       <= 32'd0;
      r_cnt_tick  <= 1'b0;
      r_tick_only <= 1'b0;
      r_halt_ack  <= 1'b0;
      r_int_set   <= 1'b0;
    end else begin
      r_lsb       <= w_lsb_nxt;
      r_msb       <= w_msb_nxt;
      r_cnt_tick  <= w_tick;
      r_tick_only <= w_tick && !tdr0_wr_en && !tdr1_wr_en;
      r_halt_ack  <= (w_state_nxt == S_HALT);
      r_int_set   <= r_tick_only && ({r_msb, r_lsb} == cmp_val);
    end
  end

  assign lsb_count = r_lsb;
  assign msb_count = r_msb;
  assign cnt_tick  = r_cnt_tick;
  assign halt_ack  = r_halt_ack;
  assign int_set   = r_int_set;

endmodule

// File: tb/tb_timer_cnt_ctrl.sv
// tb/tb_timer_cnt_ctrl.sv - self-checking bench for timer_cnt_ctrl against a cycle-level reference model
module tb_timer_cnt_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        timer_en = 1'b0;
  logic        div_en = 1'b0;
  logic [3:0]  div_val = 4'd0;
  logic        halt_req = 1'b0;
  logic        debug_mode = 1'b0;
  logic        tdr0_wr_en = 1'b0;
  logic        tdr1_wr_en = 1'b0;
  logic [31:0] wr_count = 32'd0;
  logic [63:0] cmp_val = 64'd0;
  logic [31:0] lsb_count;
  logic [31:0] msb_count;
  logic        cnt_tick;
  logic        halt_ack;
  logic        int_set;

  int vectors = 0;
  int miscompares = 0;

  timer_cnt_ctrl #(.MAX_DIV(8)) dut (
    .clk(clk), .rst(rst), .timer_en(timer_en), .div_en(div_en), .div_val(div_val),
    .halt_req(halt_req), .debug_mode(debug_mode), .tdr0_wr_en(tdr0_wr_en),
    .tdr1_wr_en(tdr1_wr_en), .wr_count(wr_count), .cmp_val(cmp_val),
    .lsb_count(lsb_count), .msb_count(msb_count), .cnt_tick(cnt_tick),
    .halt_ack(halt_ack), .int_set(int_set)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 counting, 2 halted; m_phase counts cycles since the last tick.
  int          m_mode = 0;
  int          m_phase = 0;
  logic [63:0] m_cnt = 64'd0;
  logic        m_tick = 1'b0;
  logic        m_int = 1'b0;
  logic        m_tick_only = 1'b0;
  logic [3:0]  m_prev_dv = 4'd0;

  always @(posedge clk) begin : model
    int          period;
    logic        t;
    logic [63:0] inc;
    if (rst) begin
      m_mode = 0; m_phase = 0; m_cnt = 64'd0; m_tick = 1'b0;
      m_int = 1'b0; m_tick_only = 1'b0; m_prev_dv = 4'd0;
    end else begin
      period = 1 << ((div_val > 4'd8) ? 8 : int'(div_val));
      t = 1'b0;
      if (m_mode == 0 || !div_en || div_val != m_prev_dv) m_phase = 0;
      else if (m_mode == 1) begin
        if (m_phase == period - 1) begin t = 1'b1; m_phase = 0; end
        else m_phase = m_phase + 1;
      end
      if (m_mode == 1 && !div_en) t = 1'b1;
      m_int = m_tick_only && (m_cnt == cmp_val);
      inc = m_cnt + 64'(t);
      m_cnt = {tdr1_wr_en ? wr_count : (tdr0_wr_en ? m_cnt[63:32] : inc[63:32]),
               tdr0_wr_en ? wr_count : inc[31:0]};
      m_tick_only = t && !tdr0_wr_en && !tdr1_wr_en;
      m_tick = t;
      m_prev_dv = div_val;
      if (!timer_en) m_mode = 0;
      else if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1 && halt_req && debug_mode) m_mode = 2;
      else if (m_mode == 2 && (!halt_req || !debug_mode)) m_mode = 1;
    end
  end

  task automatic do_reset();
    timer_en = 0; div_en = 0; div_val = 0; halt_req = 0; debug_mode = 0;
    tdr0_wr_en = 0; tdr1_wr_en = 0; wr_count = 0; cmp_val = 64'd0;
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; timer_en = 1; tdr0_wr_en = 1; tdr1_wr_en = 1; wr_count = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({msb_count, lsb_count} !== 64'd0) begin
      miscompares++; $display("FAIL reset_count: got %h expected 0", {msb_count, lsb_count});
    end
    vectors++;
    if ({cnt_tick, halt_ack, int_set} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 000", {cnt_tick, halt_ack, int_set});
    end
    do_reset();
  endtask

  task automatic test_free_run();
    do_reset();
    timer_en = 1;
    @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      vectors++;
      if (cnt_tick !== 1'b1) begin
        miscompares++; $display("FAIL free_run_tick[%0d]: got %b expected 1", i, cnt_tick);
      end
    end
    vectors++;
    if ({msb_count, lsb_count} !== 64'd10) begin
      miscompares++; $display("FAIL free_run_count: got %h expected 10", {msb_count, lsb_count});
    end
  endtask

  task automatic test_prescale();
    int ticks = 0;
    do_reset();
    div_en = 1; div_val = 4'd2; timer_en = 1;
    @(negedge clk);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (cnt_tick === 1'b1) ticks++;
      vectors++;
      if (cnt_tick !== ((i % 4) == 0)) begin
        miscompares++; $display("FAIL prescale_tick[%0d]: got %b expected %b", i, cnt_tick, (i % 4) == 0);
      end
    end
    vectors++;
    if (lsb_count !== 32'd4 || ticks != 4) begin
      miscompares++; $display("FAIL prescale_count: got %0d ticks %0d expected 4", lsb_count, ticks);
    end
  endtask

  task automatic test_carry();
    do_reset();
    tdr0_wr_en = 1; wr_count = 32'hFFFF_FFFF;
    @(negedge clk);
    tdr0_wr_en = 0; tdr1_wr_en = 1; wr_count = 32'd0;
    @(negedge clk);
    tdr1_wr_en = 0; timer_en = 1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({msb_count, lsb_count, cnt_tick} !== {32'd1, 32'd0, 1'b1}) begin
      miscompares++; $display("FAIL carry: got %h/%h tick %b expected 1/0 tick 1", msb_count, lsb_count, cnt_tick);
    end
    timer_en = 0;
    cmp_val = 64'd0; tdr0_wr_en = 1; tdr1_wr_en = 1; wr_count = 32'hFFFF_FFFF;
    @(negedge clk);
    tdr0_wr_en = 0; tdr1_wr_en = 0; timer_en = 1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({msb_count, lsb_count} !== 64'd0) begin
      miscompares++; $display("FAIL wrap_count: got %h expected 0", {msb_count, lsb_count});
    end
    @(negedge clk);
    vectors++;
    if (int_set !== 1'b1) begin
      miscompares++; $display("FAIL wrap_int: got %b expected 1", int_set);
    end
  endtask

  task automatic test_compare();
    int pulses = 0;
    do_reset();
    cmp_val = 64'd5; timer_en = 1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (int_set === 1'b1) pulses++;
      vectors++;
      if (int_set !== (i == 7)) begin
        miscompares++; $display("FAIL compare_int[%0d]: got %b expected %b", i, int_set, i == 7);
      end
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++; $display("FAIL compare_pulses: got %0d expected 1", pulses);
    end
    timer_en = 0;
    @(negedge clk);
    tdr0_wr_en = 1; wr_count = 32'd5;
    @(negedge clk);
    tdr0_wr_en = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (int_set !== 1'b0 || lsb_count !== 32'd5) begin
        miscompares++; $display("FAIL compare_load[%0d]: got int %b lsb %0d expected 0 / 5", i, int_set, lsb_count);
      end
    end
  endtask

  task automatic test_halt();
    logic [63:0] frozen;
    do_reset();
    div_en = 1; div_val = 4'd2; timer_en = 1;
    for (int i = 0; i < 7; i++) @(negedge clk);
    debug_mode = 1; halt_req = 1;
    @(negedge clk);
    frozen = m_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (halt_ack !== 1'b1 || {msb_count, lsb_count} !== frozen || frozen != 64'd1) begin
        miscompares++; $display("FAIL halt_hold[%0d]: got ack %b cnt %h expected 1 / 1", i, halt_ack, {msb_count, lsb_count});
      end
    end
    halt_req = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      vectors++;
      if ({halt_ack, cnt_tick} !== {1'b0, i == 2 || i == 6}) begin
        miscompares++; $display("FAIL halt_resume[%0d]: got ack %b tick %b expected 0 %b", i, halt_ack, cnt_tick, i == 2 || i == 6);
      end
    end
  endtask

  task automatic test_write_tick();
    do_reset();
    tdr1_wr_en = 1; wr_count = 32'h0000_ABCD;
    @(negedge clk);
    tdr1_wr_en = 0; tdr0_wr_en = 1; wr_count = 32'h20;
    @(negedge clk);
    tdr0_wr_en = 0; timer_en = 1;
    @(negedge clk);
    tdr0_wr_en = 1; wr_count = 32'h100;
    @(negedge clk);
    vectors++;
    if ({msb_count, lsb_count, cnt_tick} !== {32'hABCD, 32'h100, 1'b1}) begin
      miscompares++; $display("FAIL write_lsb_tick: got %h/%h tick %b expected abcd/100 tick 1", msb_count, lsb_count, cnt_tick);
    end
    tdr0_wr_en = 0; tdr1_wr_en = 1; wr_count = 32'h55;
    @(negedge clk);
    vectors++;
    if ({msb_count, lsb_count} !== {32'h55, 32'h101}) begin
      miscompares++; $display("FAIL write_msb_tick: got %h/%h expected 55/101", msb_count, lsb_count);
    end
    tdr0_wr_en = 1; wr_count = 32'h77;
    @(negedge clk);
    tdr0_wr_en = 0; tdr1_wr_en = 0;
    vectors++;
    if ({msb_count, lsb_count} !== {32'h77, 32'h77}) begin
      miscompares++; $display("FAIL write_both: got %h/%h expected 77/77", msb_count, lsb_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    div_en = 1; div_val = 4'd2; timer_en = 1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      vectors++;
      if (cnt_tick !== (i == 4)) begin
        miscompares++; $display("FAIL reset_mid_tick[%0d]: got %b expected %b", i, cnt_tick, i == 4);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      timer_en   = ($urandom_range(0, 19) != 0);
      div_en     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0)
        div_val = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      if ($urandom_range(0, 14) == 0) halt_req = ~halt_req;
      if ($urandom_range(0, 29) == 0) debug_mode = ~debug_mode;
      tdr0_wr_en = ($urandom_range(0, 24) == 0);
      tdr1_wr_en = ($urandom_range(0, 39) == 0);
      wr_count   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE + 32'($urandom_range(0, 1)) : $urandom;
      cmp_val    = m_cnt + 64'($urandom_range(0, 2));
      @(negedge clk);
      vectors++;
      if ({msb_count, lsb_count, cnt_tick, halt_ack, int_set} !== {m_cnt, m_tick, m_mode == 2, m_int}) begin
        miscompares++;
        $display("FAIL random[%0d]: got cnt %h tick %b ack %b int %b expected cnt %h tick %b ack %b int %b",
                 i, {msb_count, lsb_count}, cnt_tick, halt_ack, int_set, m_cnt, m_tick, m_mode == 2, m_int);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_prescale();
    test_carry();
    test_compare();
    test_halt();
    test_write_tick();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
